i2c_target_rx: RTL and testbench

//  I2C write-only target: the receiving end of the on-board OLED I2C link. Uses SSD1306-style framing.

---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_line_filter.sv | 56 +++++
 rtl/i2c_target_rx.sv | 165 ++++++++++++++++
 tb/tb_i2c_target_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the OLED I2C link: FSM states, control-byte fields, default address.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

    // Receiver FSM states. The byte states shift bits; the *_ACK states drive the ninth clock.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_CTRL,
        ST_CTRL_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } i2c_state_e;

    // SSD1306 control byte: Co = another control byte follows the next payload byte,
    // D/C = payload is display data (1) or a command (0).
    localparam int CTRL_CO_BIT = 7;
    localparam int CTRL_DC_BIT = 6;

    // Default OLED address, also used by the OLED master.
    localparam logic [6:0] OLED_ADDR = 7'h3C;

    // Address byte selects this target for a write transfer.
    function automatic logic addr_write_match(input logic [7:0] addr_byte,
                                              input logic [6:0] dev_addr);
        return (addr_byte[7:1] == dev_addr) && !addr_byte[0];
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronises one raw bus line and accepts a new level only after FILTER_LEN equal samples.
// Latency: 2 sync flops + FILTER_LEN samples; rise/fall pulses coincide with the level change.
// Backpressure: none; free-running conditioner.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [2:0] LAST_CNT = 3'(FILTER_LEN - 1);

    logic [1:0] sync_q;
    logic [2:0] cnt_q;
    logic       level_q;
    logic       rise_q;
    logic       fall_q;
    logic       accept_d;

    // New level has now been seen FILTER_LEN times in a row.
    assign accept_d = (sync_q[1] != level_q) && (cnt_q == LAST_CNT);

    // Sync chain, run-length counter and filtered level; everything idles high like the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            cnt_q   <= 3'd0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= 3'd0;
            end else if (accept_d) begin
                level_q <= sync_q[1];
                cnt_q   <= 3'd0;
                rise_q  <= sync_q[1];
                fall_q  <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target for the OLED link: address match, ACK, control/payload split, byte strobes.
// Latency: rx_valid one clk after the filtered SCL rise of the payload LSB.
// Backpressure: none; the consumer must take each rx_valid strobe, no clock stretching.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = OLED_ADDR,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_is_data,
    output logic       frame_start,
    output logic       frame_end,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk     (clk),
        .rst     (rst),
        .line_i  (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk     (clk),
        .rst     (rst),
        .line_i  (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    i2c_state_e state_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shreg_q;
    logic       ack_phase_q;
    logic       co_flag_q;
    logic       dc_flag_q;
    logic       sda_oe_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       rx_is_data_q;
    logic       frame_start_q;
    logic       frame_end_q;
    logic       busy_q;

    logic       start_det;
    logic       stop_det;
    logic       byte_done;
    logic [7:0] byte_d;

    // SDA may only move while SCL is low; any SDA edge with SCL high is a bus condition.
    assign start_det = sda_fall && scl_lvl;
    assign stop_det  = sda_rise && scl_lvl;
    // Completed byte including the bit being sampled on this SCL rise.
    assign byte_d    = {shreg_q, sda_lvl};
    assign byte_done = scl_rise && (bit_cnt_q == 3'd7);

    // Receiver FSM with shift register and registered outputs; bus conditions override bit traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shreg_q       <= 7'd0;
            ack_phase_q   <= 1'b0;
            co_flag_q     <= 1'b0;
            dc_flag_q     <= 1'b0;
            sda_oe_q      <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            rx_is_data_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;

            if (stop_det || start_det) begin
                // Abandon any partial byte or ACK; a repeated START reopens address decode.
                state_q     <= stop_det ? ST_IDLE : ST_ADDR;
                bit_cnt_q   <= 3'd0;
                ack_phase_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                frame_end_q <= busy_q;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR, ST_CTRL, ST_DATA: begin
                        if (scl_rise) begin
                            shreg_q   <= byte_d[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                        if (byte_done) begin
                            case (state_q)
                                ST_ADDR: begin
                                    if (addr_write_match(byte_d, DEV_ADDR)) begin
                                        state_q       <= ST_ADDR_ACK;
                                        frame_start_q <= 1'b1;
                                        busy_q        <= 1'b1;
                                    end else begin
                                        state_q <= ST_IGNORE;
                                    end
                                end
                                ST_CTRL: begin
                                    co_flag_q <= byte_d[CTRL_CO_BIT];
                                    dc_flag_q <= byte_d[CTRL_DC_BIT];
                                    state_q   <= ST_CTRL_ACK;
                                end
                                default: begin
                                    rx_data_q    <= byte_d;
                                    rx_is_data_q <= dc_flag_q;
                                    rx_valid_q   <= 1'b1;
                                    state_q      <= ST_DATA_ACK;
                                end
                            endcase
                        end
                    end
                    ST_ADDR_ACK, ST_CTRL_ACK, ST_DATA_ACK: begin
                        // First SCL fall ends bit 8 and starts the ACK slot; the second ends it.
                        if (scl_fall) begin
                            if (!ack_phase_q) begin
                                sda_oe_q    <= 1'b1;
                                ack_phase_q <= 1'b1;
                            end else begin
                                sda_oe_q    <= 1'b0;
                                ack_phase_q <= 1'b0;
                                case (state_q)
                                    ST_ADDR_ACK: state_q <= ST_CTRL;
                                    ST_CTRL_ACK: state_q <= ST_DATA;
                                    default:     state_q <= co_flag_q ? ST_CTRL : ST_DATA;
                                endcase
                            end
                        end
                    end
                    default: begin
                        // IDLE and IGNORE wait for a bus condition; SDA stays released.
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe      = sda_oe_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_is_data  = rx_is_data_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench: bit-banged I2C master on an open-drain bus model around i2c_target_rx.
// Latency: each bit phase lasts Q system clocks.
// Backpressure: n/a.
module tb_i2c_target_rx;

    localparam int Q = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_is_data;
    logic       frame_start;
    logic       frame_end;
    logic       busy;

    int checks = 0;
    int failures = 0;

    // Open-drain wired-AND of master and target.
    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_rx #(.DEV_ADDR(7'h3C), .FILTER_LEN(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (scl_m),
        .sda_i       (sda_bus),
        .sda_oe      (sda_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_is_data  (rx_is_data),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .busy        (busy)
    );

    // Strobe monitor, sampled on the falling edge.
    logic [7:0] log_d [32];
    logic       log_c [32];
    int  rv_n = 0;
    int  fs_n = 0;
    int  fe_n = 0;
    time t_fs = 0;
    time t_fe = 0;

    always @(negedge clk) begin
        if (rx_valid) begin
            if (rv_n < 32) begin
                log_d[rv_n] = rx_data;
                log_c[rv_n] = rx_is_data;
            end
            rv_n++;
        end
        if (frame_start) begin
            fs_n++;
            t_fs = $time;
        end
        if (frame_end) begin
            fe_n++;
            t_fe = $time;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b1; cyc(Q);
    endtask

    // One data bit; optional 1-clk inverted SDA glitch in the middle of SCL high.
    task automatic send_bit(input logic v, input logic g);
        sda_m = v; cyc(Q);
        scl_m = 1'b1; cyc(Q / 2);
        if (g) begin
            sda_m = ~v; cyc(1);
            sda_m = v;
        end
        cyc(Q / 2);
        scl_m = 1'b0; cyc(Q);
    endtask

    // Byte plus ACK slot; ack reports whether the target pulled SDA during SCL high.
    task automatic send_byte(input logic [7:0] b, input logic [7:0] glitch,
                             input bit rst_at_ack, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], glitch[i]);
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q / 2);
        ack = sda_oe;
        if (rst_at_ack) begin
            chk("rst_pre_oe", 32'(sda_oe), 32'd1);
            rst = 1'b1;
            #1;
            chk("rst_oe_same_cycle", 32'(sda_oe), 32'd0);
            chk("rst_rx_data", 32'(rx_data), 32'h00);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rx_is_data", 32'(rx_is_data), 32'd0);
            chk("rst_strobes", {29'd0, rx_valid, frame_start, frame_end}, 32'd0);
            cyc(2);
            rst = 1'b0;
        end
        cyc(Q / 2);
        scl_m = 1'b0; cyc(Q);
    endtask

    logic ack;
    int   b_rv, b_fs, b_fe;

    initial begin
        // Reset state
        cyc(3);
        #1;
        chk("reset_oe", 32'(sda_oe), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        chk("reset_flags", {27'd0, rx_valid, rx_is_data, frame_start, frame_end, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(20);

        // 1: 0x3C write, ctrl 0x40, A5, 5A
        b_rv = rv_n; b_fs = fs_n; b_fe = fe_n;
        i2c_start();
        send_byte(8'h78, 8'h00, 1'b0, ack); chk("t1_addr_ack", 32'(ack), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        send_byte(8'h40, 8'h00, 1'b0, ack); chk("t1_ctrl_ack", 32'(ack), 32'd1);
        send_byte(8'hA5, 8'h00, 1'b0, ack); chk("t1_d0_ack", 32'(ack), 32'd1);
        send_byte(8'h5A, 8'h00, 1'b0, ack); chk("t1_d1_ack", 32'(ack), 32'd1);
        i2c_stop();
        cyc(10);
        chk("t1_rv_count", 32'(rv_n - b_rv), 32'd2);
        chk("t1_d0", 32'(log_d[b_rv]), 32'hA5);
        chk("t1_d1", 32'(log_d[b_rv + 1]), 32'h5A);
        chk("t1_isdata", {30'd0, log_c[b_rv], log_c[b_rv + 1]}, 32'd3);
        chk("t1_fs", 32'(fs_n - b_fs), 32'd1);
        chk("t1_fe", 32'(fe_n - b_fe), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_rx_data_held", 32'(rx_data), 32'h5A);

        // 2: 0x3D ignored, then a good frame to 0x3C
        b_rv = rv_n; b_fs = fs_n; b_fe = fe_n;
        i2c_start();
        send_byte(8'h7A, 8'h00, 1'b0, ack); chk("t2_addr_nack", 32'(ack), 32'd0);
        send_byte(8'h40, 8'h00, 1'b0, ack); chk("t2_ctrl_nack", 32'(ack), 32'd0);
        send_byte(8'h12, 8'h00, 1'b0, ack); chk("t2_data_nack", 32'(ack), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        i2c_stop();
        cyc(10);
        chk("t2_no_strobes", 32'((rv_n - b_rv) + (fs_n - b_fs) + (fe_n - b_fe)), 32'd0);
        i2c_start();
        send_byte(8'h78, 8'h00, 1'b0, ack); chk("t2b_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h40, 8'h00, 1'b0, ack);
        send_byte(8'h33, 8'h00, 1'b0, ack); chk("t2b_data_ack", 32'(ack), 32'd1);
        i2c_stop();
        cyc(10);
        chk("t2b_rv_count", 32'(rv_n - b_rv), 32'd1);
        chk("t2b_data", 32'(log_d[b_rv]), 32'h33);

        // 3: Co=1 command then data
        b_rv = rv_n; b_fs = fs_n; b_fe = fe_n;
        i2c_start();
        send_byte(8'h78, 8'h00, 1'b0, ack);
        send_byte(8'h80, 8'h00, 1'b0, ack); chk("t3_ctrl0_ack", 32'(ack), 32'd1);
        send_byte(8'hAE, 8'h00, 1'b0, ack);
        send_byte(8'hC0, 8'h00, 1'b0, ack); chk("t3_ctrl1_ack", 32'(ack), 32'd1);
        send_byte(8'h11, 8'h00, 1'b0, ack); chk("t3_d1_ack", 32'(ack), 32'd1);
        i2c_stop();
        cyc(10);
        chk("t3_rv_count", 32'(rv_n - b_rv), 32'd2);
        chk("t3_d0", {23'd0, log_c[b_rv], log_d[b_rv]}, {23'd0, 1'b0, 8'hAE});
        chk("t3_d1", {23'd0, log_c[b_rv + 1], log_d[b_rv + 1]}, {23'd0, 1'b1, 8'h11});

        // 4: read request is NACKed
        b_rv = rv_n; b_fs = fs_n; b_fe = fe_n;
        i2c_start();
        send_byte(8'h79, 8'h00, 1'b0, ack); chk("t4_read_nack", 32'(ack), 32'd0);
        i2c_stop();
        cyc(10);
        chk("t4_no_fs", 32'(fs_n - b_fs), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        // 5: repeated START after 4 payload bits
        b_rv = rv_n; b_fs = fs_n; b_fe = fe_n;
        i2c_start();
        send_byte(8'h78, 8'h00, 1'b0, ack);
        send_byte(8'h00, 8'h00, 1'b0, ack);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        i2c_rstart();
        chk("t5_no_partial", 32'(rv_n - b_rv), 32'd0);
        chk("t5_fe_on_rstart", 32'(fe_n - b_fe), 32'd1);
        send_byte(8'h78, 8'h00, 1'b0, ack); chk("t5_addr_ack", 32'(ack), 32'd1);
        chk("t5_fe_before_fs", 32'(t_fe < t_fs), 32'd1);
        send_byte(8'h00, 8'h00, 1'b0, ack);
        send_byte(8'h77, 8'h00, 1'b0, ack);
        i2c_stop();
        cyc(10);
        chk("t5_rv_count", 32'(rv_n - b_rv), 32'd1);
        chk("t5_data", {23'd0, log_c[b_rv], log_d[b_rv]}, {23'd0, 1'b0, 8'h77});
        chk("t5_fs_fe", {16'(fs_n - b_fs), 16'(fe_n - b_fe)}, {16'd2, 16'd2});

        // 6a: 1-clk SDA glitches while SCL high must not be START/STOP
        b_rv = rv_n; b_fs = fs_n; b_fe = fe_n;
        i2c_start();
        send_byte(8'h78, 8'h00, 1'b0, ack);
        send_byte(8'h40, 8'h00, 1'b0, ack);
        send_byte(8'hA0, 8'hC0, 1'b0, ack); chk("t6_glitch_ack", 32'(ack), 32'd1);
        chk("t6_glitch_busy", 32'(busy), 32'd1);
        i2c_stop();
        cyc(10);
        chk("t6_glitch_rv", 32'(rv_n - b_rv), 32'd1);
        chk("t6_glitch_data", 32'(log_d[b_rv]), 32'hA0);
        chk("t6_glitch_fe", 32'(fe_n - b_fe), 32'd1);

        // 6b: reset pulse during the address ACK
        b_rv = rv_n; b_fs = fs_n; b_fe = fe_n;
        i2c_start();
        send_byte(8'h78, 8'h00, 1'b1, ack);
        i2c_stop();
        cyc(10);
        chk("t6_rst_fe", 32'(fe_n - b_fe), 32'd0);
        chk("t6_rst_oe_idle", 32'(sda_oe), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
